// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 subordinate with an ADXL362-style 8-bit register file (0x0A write, 0x0B read).
// Optional build macro SPI_PERIPHERAL_BURST_EN enables multi-byte, auto-incrementing transfers. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module spi_peripheral #(
  parameter int         CLK_FREQUENCY = 100_000_000,
  parameter int         NUM_REGS      = 64,
  parameter logic [7:0] DEVID_VAL     = 8'hAD,
  parameter logic [7:0] PARTID_VAL    = 8'hF2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [7:0] status_in,
  output logic       reg_wr_valid,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  localparam int         AW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] CMD_WR        = 8'h0A;
  localparam logic [7:0] CMD_RD        = 8'h0B;
  localparam logic [7:0] SOFT_RST_ADDR = 8'h1F;
  localparam logic [7:0] SOFT_RST_KEY  = 8'h52;
`ifdef SPI_PERIPHERAL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  // Legal configurations generate nothing here; SCLK must stay at or below CLK_FREQUENCY/8.
  if (CLK_FREQUENCY < 8 || NUM_REGS > 256) begin : g_param_range
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_ADDR    = 3'd2,
    S_WR_DATA = 3'd3,
    S_RD_DATA = 3'd4,
    S_IGNORE  = 3'd5
  } state_t;

  state_t state, state_n;

  logic [1:0] sclk_sync, mosi_sync, cs_sync;
  logic       sclk_d, cs_d, armed;
  logic       sclk_s, mosi_s, cs_s;
  logic       rise, fall, cs_fall, byte_done;

  logic [2:0] bitcnt;
  logic [6:0] shift_in;
  logic [7:0] shift_out;
  logic [7:0] addr;
  logic       is_wr;
  logic [7:0] regs [NUM_REGS];

  logic [7:0] sh_next, rd_addr, rd_data;
  logic       wr_ok;

  // cs flops reset "low" so a cs held low across reset never looks like a fresh fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b0;
      armed     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      if (cs_sync[1]) armed <= 1'b1;
      busy      <= armed & ~cs_sync[1];
    end
  end

  assign sclk_s    = sclk_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign cs_s      = cs_sync[1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;
  assign byte_done = rise & (bitcnt == 3'd7);
  assign sh_next   = {shift_in, mosi_s};

  function automatic logic implemented(input logic [7:0] a);
    return int'({24'd0, a}) < NUM_REGS;
  endfunction

  function automatic logic read_only(input logic [7:0] a);
    return (a <= 8'h03) || (a == 8'h0B);
  endfunction

  assign wr_ok   = implemented(addr) && !read_only(addr);
  assign rd_addr = (state == S_ADDR) ? sh_next : addr + 8'd1;

  always_comb begin
    rd_data = 8'h00;
    case (rd_addr)
      8'h00:   rd_data = DEVID_VAL;
      8'h01:   rd_data = 8'h1D;
      8'h02:   rd_data = PARTID_VAL;
      8'h03:   rd_data = 8'h01;
      8'h0B:   rd_data = status_in;
      default: if (implemented(rd_addr)) rd_data = regs[rd_addr[AW-1:0]];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (cs_fall) state_n = S_CMD;
      S_CMD:     if (byte_done)
                   state_n = (sh_next == CMD_WR || sh_next == CMD_RD) ? S_ADDR : S_IGNORE;
      S_ADDR:    if (byte_done) state_n = is_wr ? S_WR_DATA : S_RD_DATA;
      S_WR_DATA,
      S_RD_DATA: if (byte_done && !BURST) state_n = S_IGNORE;
      default:   state_n = state;
    endcase
    if (cs_s) state_n = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitcnt       <= '0;
      shift_in     <= '0;
      shift_out    <= '0;
      addr         <= '0;
      is_wr        <= 1'b0;
      miso         <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= '0;
      reg_wr_data  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_wr_valid <= 1'b0;
      if (cs_s || state == S_IDLE) begin
        bitcnt <= '0;
        miso   <= 1'b0;
      end else begin
        if (rise && state != S_IGNORE) begin
          shift_in <= sh_next[6:0];
          bitcnt   <= bitcnt + 3'd1;
        end
        case (state)
          S_CMD: if (byte_done) is_wr <= (sh_next == CMD_WR);
          S_ADDR: if (byte_done) begin
            addr      <= sh_next;
            shift_out <= rd_data;
          end
          S_RD_DATA: begin
            if (fall) begin
              miso      <= shift_out[7];
              shift_out <= {shift_out[6:0], 1'b0};
            end
            if (byte_done) begin
              if (BURST) begin
                addr      <= addr + 8'd1;
                shift_out <= rd_data;
              end else begin
                miso <= 1'b0;
              end
            end
          end
          S_WR_DATA: if (byte_done) begin
            if (wr_ok) begin
              reg_wr_valid <= 1'b1;
              reg_wr_addr  <= addr;
              reg_wr_data  <= sh_next;
              if (addr == SOFT_RST_ADDR && sh_next == SOFT_RST_KEY) begin
                for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
              end else begin
                regs[addr[AW-1:0]] <= sh_next;
              end
            end
            if (BURST) addr <= addr + 8'd1;
          end
          S_IGNORE: miso <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed + random SPI transactions checked against a register-map model.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_peripheral;

  localparam int NUM_REGS = 64;
`ifdef SPI_PERIPHERAL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, cs, miso, reg_wr_valid, busy;
  logic [7:0] status_in, reg_wr_addr, reg_wr_data;

  int total = 0;
  int bad   = 0;
  int half_ns = 40;

  logic [7:0]  tx_q[$];
  logic [7:0]  rx_bytes[$];
  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];
  logic [7:0]  mregs[256];
  logic [7:0]  rd_byte;
  logic        busy_seen;

  always #5 clk = ~clk;

  spi_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .status_in(status_in), .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .busy(busy)
  );

  always @(negedge clk) if (reg_wr_valid) wr_q.push_back({reg_wr_addr, reg_wr_data});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register-map model
  function automatic bit m_writable(input logic [7:0] a);
    return (int'(a) < NUM_REGS) && !(a inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h0B});
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return 8'hAD;
      8'h01:   return 8'h1D;
      8'h02:   return 8'hF2;
      8'h03:   return 8'h01;
      8'h0B:   return status_in;
      default: return (int'(a) < NUM_REGS) ? mregs[a] : 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (m_writable(a)) begin
      exp_q.push_back({a, d});
      if (a == 8'h1F && d == 8'h52) foreach (mregs[i]) mregs[i] = 8'h00;
      else mregs[a] = d;
    end
  endtask

  task automatic xfer(input int nbits, input bit own_cs);
    logic [7:0] cur;
    int nb;
    rx_bytes.delete();
    cur = 8'h00;
    nb  = 0;
    @(posedge clk); #2;
    if (own_cs) cs = 1'b0;
    #(half_ns);
    for (int i = 0; i < nbits; i++) begin
      cur  = tx_q[i / 8];
      mosi = cur[7 - (i % 8)];
      cur  = (nb == 0) ? 8'h00 : (rx_bytes.size() > 0 ? cur : cur);
      #(half_ns);
      sclk = 1'b1;
      if (i == 0) busy_seen = busy;
      if (nb == 0) cur = 8'h00; else cur = rx_bytes.pop_back();
      cur = {cur[6:0], miso};
      rx_bytes.push_back(cur);
      nb = (nb + 1) % 8;
      #(half_ns);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    #(half_ns);
    if (own_cs) cs = 1'b1;
    #(half_ns + 60);
  endtask

  // Runs tx_q as one transaction; decode=0 means the DUT must not respond at all.
  task automatic run_txn(input string tag, input int nbits, input bit own_cs = 1'b1,
                         input bit decode = 1'b1);
    logic [7:0] cmd, a, e;
    int nfull, rem;
    wr_q.delete();
    exp_q.delete();
    cmd   = tx_q[0];
    a     = (nbits >= 16) ? tx_q[1] : 8'h00;
    nfull = nbits / 8;
    rem   = nbits % 8;
    xfer(nbits, own_cs);
    if (decode && cmd == 8'h0A && nbits >= 16)
      for (int k = 0; 2 + k < nfull; k++)
        if (BURST || k == 0) m_write(a + 8'(k), tx_q[2 + k]);
    for (int i = 0; i < rx_bytes.size(); i++) begin
      e = 8'h00;
      if (decode && cmd == 8'h0B && i >= 2 && (BURST || i == 2)) e = m_read(a + 8'(i - 2));
      if (i == rx_bytes.size() - 1 && rem != 0) e = e >> (8 - rem);
      check($sformatf("%s rx%0d", tag, i), {8'h00, rx_bytes[i]}, {8'h00, e});
    end
    rd_byte = (rx_bytes.size() > 2) ? rx_bytes[2] : 8'h00;
    check($sformatf("%s wr_count", tag), 16'(wr_q.size()), 16'(exp_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s wr%0d", tag, i), wr_q[i], exp_q[i]);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    tx_q = '{8'h0A, a, d};
    run_txn($sformatf("wr%02h", a), 24);
  endtask

  task automatic rd(input logic [7:0] a, input int nbytes = 1);
    tx_q = '{8'h0B, a};
    for (int i = 0; i < nbytes; i++) tx_q.push_back(8'h00);
    run_txn($sformatf("rd%02h", a), 16 + 8 * nbytes);
  endtask

  task automatic directed(input bit full);
    rd(8'h00);  check("devid", {8'h00, rd_byte}, 16'h00AD);
    check("busy_in_txn", {15'd0, busy_seen}, 16'd1);
    rd(8'h02);  check("partid", {8'h00, rd_byte}, 16'h00F2);
    wr(8'h20, 8'h5A);
    check("wr20_pulses", 16'(wr_q.size()), 16'd1);
    rd(8'h20);  check("rd20", {8'h00, rd_byte}, 16'h005A);
    status_in = 8'h41;
    rd(8'h0B);  check("status", {8'h00, rd_byte}, 16'h0041);
    wr(8'h00, 8'hFF);
    check("ro_no_pulse", 16'(wr_q.size()), 16'd0);
    rd(8'h00);  check("devid_kept", {8'h00, rd_byte}, 16'h00AD);
    if (full) begin
      wr(8'h20, 8'h5A);
      wr(8'h1F, 8'h52);
      check("softrst_pulse", 16'(wr_q.size()), 16'd1);
      rd(8'h20);  check("softrst_20", {8'h00, rd_byte}, 16'h0000);
      rd(8'h1F);  check("softrst_1f", {8'h00, rd_byte}, 16'h0000);
      tx_q = '{8'h0A, 8'h21, 8'hF0};
      run_txn("partial", 20);
      rd(8'h21);  check("partial_21", {8'h00, rd_byte}, 16'h0000);
      tx_q = '{8'h55, 8'h00, 8'h00};
      run_txn("badcmd", 24);
      tx_q = '{8'h0A, 8'h3F, 8'h11, 8'h22};
      run_txn("burst_wr", 32);
      rd(8'h3E, 2);
      check("burst_rd1", {8'h00, rx_bytes[3]}, BURST ? 16'h0011 : 16'h0000);
      rd(8'hFF, 2);
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; status_in = 8'h00;
    foreach (mregs[i]) mregs[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso",  {15'd0, miso}, 16'd0);
    check("rst_busy",  {15'd0, busy}, 16'd0);
    check("rst_valid", {15'd0, reg_wr_valid}, 16'd0);
    check("rst_wr_addr_data", {reg_wr_addr, reg_wr_data}, 16'h0000);
    @(negedge clk); rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy", {15'd0, busy}, 16'd0);
    check("post_rst_miso", {15'd0, miso}, 16'd0);

    half_ns = 40;
    directed(1'b1);

    // Reset asserted while cs is low; cs stays low through release.
    wr(8'h25, 8'h66);
    @(posedge clk); #2; cs = 1'b0;
    repeat (20) @(posedge clk);
    #2; rst = 1'b1;
    #30 rst = 1'b0;
    foreach (mregs[i]) mregs[i] = 8'h00;
    tx_q = '{8'h0A, 8'h26, 8'h77};
    run_txn("cs_low_thru_rst", 24, 1'b0, 1'b0);
    cs = 1'b1;
    #200;
    rd(8'h25);  check("rst_cleared_25", {8'h00, rd_byte}, 16'h0000);
    rd(8'h26);  check("no_decode_26", {8'h00, rd_byte}, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] cmd, a;
      int kind, nbytes, nbits;
      half_ns   = 40 + 10 * $urandom_range(0, 2);
      status_in = 8'($urandom);
      kind      = $urandom_range(0, 5);
      cmd       = (kind <= 2) ? 8'h0A : (kind <= 4) ? 8'h0B : (8'($urandom) | 8'h80);
      a         = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
      nbytes    = $urandom_range(1, 3);
      tx_q      = '{cmd, a};
      for (int i = 0; i < nbytes; i++) tx_q.push_back(8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        tx_q[1] = 8'h1F;
        tx_q[2] = 8'h52;
      end
      nbits = (2 + nbytes) * 8;
      if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
      run_txn($sformatf("rand%0d", n), nbits);
    end

    half_ns = 1000;
    directed(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
